// File: rtl/player_core.sv
// Per-player controller: spawn, movement, carry/deposit scoring, lives, respawn blink, sprite addressing.
// Latency: all state registers on FrameClk; sprite/pixel outputs are combinational from registered state.
// Backpressure: none; one update per frame, inputs sampled every FrameClk edge.
module player_core #(
    parameter int PLAYER_IDX      = 1,
    parameter int MAX_ITEMS       = 3,
    parameter int LIVES           = 3,
    parameter int SPAWN_X         = 292,
    parameter int SPAWN_Y         = 400,
    parameter int MIN_X           = 100,
    parameter int MAX_X           = 739,
    parameter int MIN_Y           = 65,
    parameter int MAX_Y           = 448,
    parameter int SIZE            = 32,
    parameter int FRAMES_PER_TILE = 5,
    parameter int TILES_PER_ANIM  = 8,
    parameter int MOVE_DIV        = 2,
    parameter int INVULN_FRAMES   = 90,
    parameter int SCORE_W         = 8
) (
    input  logic               FrameClk,
    input  logic               ResetN,
    input  logic               SpawnEnable,
    input  logic               Hit,
    input  logic [1:0]         Collect,
    input  logic               Deposit,
    input  logic [2:0]         Speed,
    input  logic [7:0]         Keycode,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [9:0]         PlayerX,
    output logic [9:0]         PlayerY,
    output logic               PlayerPixel,
    output logic [7:0]         Tile,
    output logic [4:0]         PixelX,
    output logic [4:0]         PixelY,
    output logic [2:0]         Items,
    output logic [SCORE_W-1:0] Score,
    output logic [2:0]         Lives,
    output logic               Collected,
    output logic               Deposited,
    output logic               Dead,
    output logic               GameOver,
    output logic               Invuln
);
    localparam logic [2:0] ST_UNSPAWNED = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_WALK      = 3'd2;
    localparam logic [2:0] ST_DEAD1     = 3'd3;
    localparam logic [2:0] ST_DEAD2     = 3'd4;
    localparam logic [2:0] ST_OVER      = 3'd5;
    localparam int INV_W = 16;

    logic [2:0]         state_q, state_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic               face_left_q, face_left_d;
    logic [2:0]         items_q, items_d;
    logic [4:0]         carry_q, carry_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic [7:0]         frame_q, frame_d, tile_q, tile_d, move_q, move_d;
    logic [INV_W-1:0]   inv_q, inv_d;
    logic               collected_q, collected_d, deposited_q, deposited_d;

    // Shared decode of keys, counters and accepted events
    logic key_l, key_r, key_u, key_dn, go_x, go_y;
    logic alive, frame_wrap, tile_wrap, move_frame, hit_take, collect_take;
    logic [2:0] step;
    logic [SCORE_W:0] score_sum;
    logic unused_keys;

    assign key_l        = Keycode[4*PLAYER_IDX];
    assign key_r        = Keycode[4*PLAYER_IDX+1];
    assign key_u        = Keycode[4*PLAYER_IDX+2];
    assign key_dn       = Keycode[4*PLAYER_IDX+3];
    assign unused_keys  = ^Keycode;
    assign go_x         = key_l ^ key_r;
    assign go_y         = key_u ^ key_dn;
    assign alive        = (state_q == ST_IDLE) || (state_q == ST_WALK);
    assign frame_wrap   = (frame_q == 8'(FRAMES_PER_TILE - 1));
    assign tile_wrap    = frame_wrap && (tile_q == 8'(TILES_PER_ANIM - 1));
    assign move_frame   = (move_q == 8'd0);
    assign hit_take     = alive && Hit && (inv_q == '0);
    assign collect_take = (Collect != 2'd0) && (items_q < 3'(MAX_ITEMS));
    // Fewer pixels per move as the load grows, but never a zero step
    assign step         = (Speed > items_q) ? (Speed - items_q) : 3'd1;
    assign score_sum    = {1'b0, score_q} + (SCORE_W+1)'(carry_q);

    // State and datapath registers; reset and despawn share the same effect
    always_ff @(posedge FrameClk) begin
        if (!ResetN || !SpawnEnable) begin
            state_q     <= ST_UNSPAWNED;
            x_q         <= 10'(SPAWN_X);
            y_q         <= 10'(SPAWN_Y);
            face_left_q <= (PLAYER_IDX == 0);
            items_q     <= 3'd0;
            carry_q     <= 5'd0;
            score_q     <= '0;
            lives_q     <= 3'(LIVES);
            frame_q     <= 8'd0;
            tile_q      <= 8'd0;
            move_q      <= 8'd0;
            inv_q       <= '0;
            collected_q <= 1'b0;
            deposited_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            face_left_q <= face_left_d;
            items_q     <= items_d;
            carry_q     <= carry_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            frame_q     <= frame_d;
            tile_q      <= tile_d;
            move_q      <= move_d;
            inv_q       <= inv_d;
            collected_q <= collected_d;
            deposited_q <= deposited_d;
        end
    end

    // Next-state: spawn, walk/idle on move frames, death animation sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNSPAWNED: state_d = ST_IDLE;
            ST_IDLE, ST_WALK: begin
                if (hit_take)        state_d = ST_DEAD1;
                else if (move_frame) state_d = (go_x || go_y) ? ST_WALK : ST_IDLE;
            end
            ST_DEAD1: if (tile_wrap) state_d = ST_DEAD2;
            ST_DEAD2: if (tile_wrap) state_d = (lives_q != 3'd0) ? ST_UNSPAWNED : ST_OVER;
            ST_OVER:  state_d = ST_OVER;
            default:  state_d = ST_UNSPAWNED;
        endcase
    end

    // Datapath: animation counters, movement with clamping, pickups, deposits, lives
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        face_left_d = face_left_q;
        items_d     = items_q;
        carry_d     = carry_q;
        score_d     = score_q;
        lives_d     = lives_q;
        frame_d     = frame_q;
        tile_d      = tile_q;
        move_d      = 8'd0;
        inv_d       = inv_q;
        collected_d = 1'b0;
        deposited_d = 1'b0;
        if (state_q != ST_UNSPAWNED && state_q != ST_OVER) begin
            frame_d = frame_wrap ? 8'd0 : frame_q + 8'd1;
            if (frame_wrap) tile_d = (tile_q == 8'(TILES_PER_ANIM - 1)) ? 8'd0 : tile_q + 8'd1;
        end
        case (state_q)
            ST_UNSPAWNED: begin
                x_d         = 10'(SPAWN_X);
                y_d         = 10'(SPAWN_Y);
                face_left_d = (PLAYER_IDX == 0);
                items_d     = 3'd0;
                carry_d     = 5'd0;
                frame_d     = 8'd0;
                tile_d      = 8'd0;
                inv_d       = INV_W'(INVULN_FRAMES);
            end
            ST_IDLE, ST_WALK: begin
                move_d = (move_q == 8'(MOVE_DIV - 1)) ? 8'd0 : move_q + 8'd1;
                if (inv_q != '0) inv_d = inv_q - 1'b1;
                if (hit_take) begin
                    frame_d = 8'd0;
                    tile_d  = 8'd0;
                    move_d  = 8'd0;
                    lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                    items_d = 3'd0;
                    carry_d = 5'd0;
                end else begin
                    if (move_frame && go_x) begin
                        face_left_d = key_l;
                        if (key_l)
                            x_d = ({1'b0, x_q} < 11'(MIN_X) + 11'(step)) ? 10'(MIN_X) : x_q - 10'(step);
                        else
                            x_d = ({1'b0, x_q} + 11'(step) > 11'(MAX_X - SIZE)) ? 10'(MAX_X - SIZE) : x_q + 10'(step);
                    end
                    if (move_frame && go_y) begin
                        if (key_u)
                            y_d = ({1'b0, y_q} < 11'(MIN_Y) + 11'(step)) ? 10'(MIN_Y) : y_q - 10'(step);
                        else
                            y_d = ({1'b0, y_q} + 11'(step) > 11'(MAX_Y - SIZE)) ? 10'(MAX_Y - SIZE) : y_q + 10'(step);
                    end
                    if (collect_take) begin
                        items_d     = items_q + 3'd1;
                        carry_d     = carry_q + 5'(Collect);
                        collected_d = 1'b1;
                    end else if (Deposit && items_q != 3'd0) begin
                        score_d     = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                        items_d     = 3'd0;
                        carry_d     = 5'd0;
                        deposited_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Sprite addressing and status flags derived from registered state
    always_comb begin
        int anim;
        logic in_box;
        anim = 0;
        case (state_q)
            ST_WALK:  anim = 1;
            ST_DEAD1: anim = 2;
            ST_DEAD2: anim = 3;
            default:  anim = 0;
        endcase
        Tile     = 8'(((anim * TILES_PER_ANIM) + int'(tile_q)) * (MAX_ITEMS + 1) + int'(items_q));
        PixelY   = DrawY[4:0] - y_q[4:0];
        PixelX   = DrawX[4:0] - x_q[4:0];
        if (face_left_q) PixelX = 5'(SIZE - 1) - PixelX;
        in_box   = (DrawX >= x_q) && ({1'b0, DrawX} < {1'b0, x_q} + 11'(SIZE)) &&
                   (DrawY >= y_q) && ({1'b0, DrawY} < {1'b0, y_q} + 11'(SIZE));
        PlayerPixel = in_box && (state_q != ST_UNSPAWNED) && (state_q != ST_OVER) &&
                      !((inv_q != '0) && inv_q[2]);
        Dead     = (state_q == ST_DEAD1) || (state_q == ST_DEAD2) || (state_q == ST_OVER);
        GameOver = (state_q == ST_OVER);
    end

    assign PlayerX   = x_q;
    assign PlayerY   = y_q;
    assign Items     = items_q;
    assign Score     = score_q;
    assign Lives     = lives_q;
    assign Collected = collected_q;
    assign Deposited = deposited_q;
    assign Invuln    = (inv_q != '0);
endmodule
